// File: rtl/sram_burst_ctrl_pkg.sv
// Shared types and default parameters for the SRAM burst controller.
// Also holds a width helper that never returns zero.
package sram_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int          DEF_DATA_W      = 32;
  localparam int          DEF_SRAM_ADDR_W = 17;
  localparam logic [31:0] DEF_BASE_ADDR   = 32'd1024;
  localparam int          DEF_WAIT_CYCLES = 3;
  localparam int          DEF_BURST_LEN   = 2;

  // Counter width that stays at least one bit, even for a one-beat burst.
  function automatic int clog2_min1(input int v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

endpackage

// File: rtl/sram_burst_ctrl_if.sv
// Host-side request/response bundle of the SRAM burst controller.
interface sram_burst_ctrl_if
  import sram_ctrl_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int BURST_LEN = DEF_BURST_LEN
);
  logic                          write_en;
  logic                          read_en;
  logic [31:0]                   address;
  logic [DATA_W-1:0]             writeData;
  logic [DATA_W*BURST_LEN-1:0]   readData;
  logic                          ready;

  modport master (output write_en, read_en, address, writeData, input readData, ready);
  modport slave  (input write_en, read_en, address, writeData, output readData, ready);
endinterface

// File: rtl/sram_burst_ctrl_beat_timer.sv
// Wait-state and beat counters shared by the write and read phases.
module sram_beat_timer
  import sram_ctrl_pkg::*;
#(
  parameter int WAIT_CYCLES = DEF_WAIT_CYCLES,
  parameter int BURST_LEN   = DEF_BURST_LEN,
  localparam int BEAT_W     = clog2_min1(BURST_LEN)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_run,
  output logic              o_beat_end,
  output logic              o_last_beat,
  output logic [BEAT_W-1:0] o_beat_idx
);
  logic [3:0]        r_wait;
  logic [BEAT_W-1:0] r_beat;

  assign o_beat_end  = i_run && (r_wait == 4'(WAIT_CYCLES));
  assign o_last_beat = (r_beat == BEAT_W'(BURST_LEN - 1));
  assign o_beat_idx  = r_beat;

  // Counters idle at zero so every access starts from a clean beat 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wait <= '0;
      r_beat <= '0;
    end else if (!i_run) begin
      r_wait <= '0;
      r_beat <= '0;
    end else if (o_beat_end) begin
      r_wait <= '0;
      r_beat <= o_last_beat ? '0 : r_beat + BEAT_W'(1);
    end else begin
      r_wait <= r_wait + 4'd1;
    end
  end
endmodule

// File: rtl/sram_burst_ctrl.sv
// Single-word write / aligned burst read controller for an asynchronous SRAM
// with a fixed number of wait states per access.
module sram_burst_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int          DATA_W      = DEF_DATA_W,
  parameter int          SRAM_ADDR_W = DEF_SRAM_ADDR_W,
  parameter logic [31:0] BASE_ADDR   = DEF_BASE_ADDR,
  parameter int          WAIT_CYCLES = DEF_WAIT_CYCLES,
  parameter int          BURST_LEN   = DEF_BURST_LEN
) (
  input  logic                   clk,
  input  logic                   rst,
  sram_burst_ctrl_if.slave       bus,
  inout  wire  [DATA_W-1:0]      SRAM_DQ,
  output logic [SRAM_ADDR_W-1:0] SRAM_ADDR,
  output logic                   SRAM_WE_N
);
  localparam int BYTE_SH = $clog2(DATA_W / 8);
  localparam int BEAT_W  = clog2_min1(BURST_LEN);

  state_t                 r_state, w_state_next;
  logic [SRAM_ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0]      r_wdata;
  logic [DATA_W-1:0]      r_beat_data [BURST_LEN];
  logic [31:0]            w_offset;
  logic [SRAM_ADDR_W-1:0] w_word, w_rd_start;
  logic                   w_run, w_beat_end, w_last_beat, w_ready;
  logic [BEAT_W-1:0]      w_beat_idx;

  assign w_offset   = bus.address - BASE_ADDR;
  assign w_word     = SRAM_ADDR_W'(w_offset >> BYTE_SH);
  assign w_rd_start = w_word & ~SRAM_ADDR_W'(BURST_LEN - 1);
  assign w_run      = (r_state == ST_WRITE) || (r_state == ST_READ);

  sram_beat_timer #(
    .WAIT_CYCLES (WAIT_CYCLES),
    .BURST_LEN   (BURST_LEN)
  ) u_timer (
    .clk         (clk),
    .rst         (rst),
    .i_run       (w_run),
    .o_beat_end  (w_beat_end),
    .o_last_beat (w_last_beat),
    .o_beat_idx  (w_beat_idx)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_ready      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_ready = !(bus.read_en || bus.write_en);
        if (bus.read_en)       w_state_next = ST_READ;
        else if (bus.write_en) w_state_next = ST_WRITE;
      end
      ST_WRITE: if (w_beat_end) w_state_next = ST_DONE;
      ST_READ:  if (w_beat_end && w_last_beat) w_state_next = ST_DONE;
      ST_DONE: begin
        w_ready      = 1'b1;
        w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Address and write word are latched on acceptance so a request dropped
  // mid-transaction cannot disturb the access in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr  <= '0;
      r_wdata <= '0;
    end else if (r_state == ST_IDLE) begin
      if (bus.read_en) begin
        r_addr <= w_rd_start;
      end else if (bus.write_en) begin
        r_addr  <= w_word;
        r_wdata <= bus.writeData;
      end
    end else if (r_state == ST_READ && w_beat_end && !w_last_beat) begin
      r_addr <= r_addr + SRAM_ADDR_W'(1);
    end
  end

  for (genvar gi = 0; gi < BURST_LEN; gi++) begin : g_beat
    always_ff @(posedge clk or posedge rst) begin
      if (rst)
        r_beat_data[gi] <= '0;
      else if (r_state == ST_READ && w_beat_end && w_beat_idx == BEAT_W'(gi))
        r_beat_data[gi] <= SRAM_DQ;
    end
    assign bus.readData[gi*DATA_W +: DATA_W] = r_beat_data[gi];
  end

  assign bus.ready = w_ready;
  assign SRAM_ADDR = r_addr;
  assign SRAM_WE_N = (r_state != ST_WRITE);
  assign SRAM_DQ   = (r_state == ST_WRITE) ? r_wdata : {DATA_W{1'bz}};
endmodule

// File: tb/tb_sram_burst_ctrl.sv
// Randomised transaction bench for sram_burst_ctrl with a transaction-level
// expectation model, an SRAM device model and a few hand-computed anchors.
module tb_sram_burst_ctrl;
  import sram_ctrl_pkg::*;

  localparam int          DW   = 32;
  localparam int          AW   = 17;
  localparam int          W    = 3;
  localparam int          BL   = 2;
  localparam int          W2   = 0;
  localparam int          BL2  = 4;
  localparam logic [31:0] BASE = 32'd1024;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sram_burst_ctrl_if #(.DATA_W(DW), .BURST_LEN(BL))  bus ();
  sram_burst_ctrl_if #(.DATA_W(DW), .BURST_LEN(BL2)) bus2 ();

  wire  [DW-1:0] dq, dq2;
  logic [AW-1:0] sram_addr, sram_addr2;
  logic          we_n, we_n2;

  sram_burst_ctrl #(.DATA_W(DW), .SRAM_ADDR_W(AW), .BASE_ADDR(BASE),
                    .WAIT_CYCLES(W), .BURST_LEN(BL)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .SRAM_DQ(dq), .SRAM_ADDR(sram_addr), .SRAM_WE_N(we_n));

  sram_burst_ctrl #(.DATA_W(DW), .SRAM_ADDR_W(AW), .BASE_ADDR(BASE),
                    .WAIT_CYCLES(W2), .BURST_LEN(BL2)) dut2 (
    .clk(clk), .rst(rst), .bus(bus2),
    .SRAM_DQ(dq2), .SRAM_ADDR(sram_addr2), .SRAM_WE_N(we_n2));

  // SRAM device: drives the bus whenever not being written.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  wire  [DW-1:0] dev_drive  = mem[sram_addr];
  wire  [DW-1:0] dev_drive2 = mem[sram_addr2];
  assign dq  = we_n  ? dev_drive  : {DW{1'bz}};
  assign dq2 = we_n2 ? dev_drive2 : {DW{1'bz}};
  always @(posedge clk) if (!we_n) mem[sram_addr] <= dq;

  // Reference memory contents.
  logic [31:0] model_mem [logic [AW-1:0]];
  function automatic logic [31:0] init_val(input logic [AW-1:0] w);
    return (32'(w) * 32'h9E3779B1) ^ 32'hC0FFEE11;
  endfunction
  function automatic logic [31:0] model_rd(input logic [AW-1:0] w);
    return model_mem.exists(w) ? model_mem[w] : init_val(w);
  endfunction
  function automatic logic [AW-1:0] word_of(input logic [31:0] addr);
    logic [31:0] d;
    d = addr - BASE;
    return AW'(d >> 2);
  endfunction

  int n_cmp = 0;
  int n_bad = 0;
  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h required %h at %0t", name, act, exp, $time);
    end
  endtask

  bit            exp_valid = 0;
  logic          exp_ready, exp_we_n;
  bit            exp_addr_chk, exp_dq_val;
  logic [AW-1:0] exp_addr;
  logic [31:0]   exp_dq;
  logic [63:0]   exp_rdata = '0;

  always @(negedge clk) begin
    if (exp_valid && !rst) begin
      check("ready", 128'(bus.ready), 128'(exp_ready));
      check("we_n", 128'(we_n), 128'(exp_we_n));
      check("readData", 128'(bus.readData), 128'(exp_rdata));
      if (exp_addr_chk) check("sram_addr", 128'(sram_addr), 128'(exp_addr));
      if (exp_dq_val) check("dq_value", 128'(dq), 128'(exp_dq));
      else            check("dq_released", 128'(dq), 128'(dev_drive));
    end
  end

  int            we_low_cnt = 0;
  logic [AW-1:0] last_we_addr = '0;
  always @(negedge clk) begin
    if (!rst && !we_n) begin
      we_low_cnt++;
      last_we_addr = sram_addr;
    end
  end

  // One transaction; expectations derived per cycle offset t from the request.
  task automatic do_txn(input bit rd, input bit both, input logic [31:0] addr,
                        input logic [31:0] data, input bit drop, input bit hold_next);
    int L;
    logic [AW-1:0] w, start;
    w     = word_of(addr);
    start = w & ~AW'(BL - 1);
    L     = rd ? BL * (W + 1) + 1 : W + 2;
    for (int t = 0; t <= L; t++) begin
      @(posedge clk); #1;
      if (t == 0) begin
        bus.read_en   = rd;
        bus.write_en  = !rd || both;
        bus.address   = addr;
        bus.writeData = data;
      end else if (t == 1 && drop) begin
        bus.read_en  = 1'b0;
        bus.write_en = 1'b0;
      end else if (t == L && !hold_next) begin
        bus.read_en  = 1'b0;
        bus.write_en = 1'b0;
      end
      exp_ready    = (t == L);
      exp_we_n     = !(!rd && t >= 1 && t <= W + 1);
      exp_addr_chk = (t >= 1 && t < L);
      exp_addr     = rd ? start + AW'((t - 1) / (W + 1)) : w;
      exp_dq_val   = exp_addr_chk;
      exp_dq       = rd ? model_rd(exp_addr) : data;
      if (rd)
        for (int k = 0; k < BL; k++)
          if (t > (k + 1) * (W + 1)) exp_rdata[k*32 +: 32] = model_rd(start + AW'(k));
      exp_valid = 1;
    end
    if (!rd) model_mem[w] = data;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      bus.read_en  = 1'b0;
      bus.write_en = 1'b0;
      exp_ready = 1'b1; exp_we_n = 1'b1; exp_addr_chk = 0; exp_dq_val = 0;
      exp_valid = 1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int wl0, done_t;
    logic [127:0] exp2;
    for (int i = 0; i < (1 << AW); i++) mem[i] = init_val(AW'(i));
    bus.read_en = 0;  bus.write_en = 0;  bus.address = '0;  bus.writeData = '0;
    bus2.read_en = 0; bus2.write_en = 0; bus2.address = '0; bus2.writeData = '0;

    repeat (2) @(posedge clk); #1;
    check("rst_readData", 128'(bus.readData), 128'(0));
    check("rst_we_n", 128'(we_n), 128'(1));
    check("rst_sram_addr", 128'(sram_addr), 128'(0));
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    check("ready_after_rst", 128'(bus.ready), 128'(1));
    idle(2);

    // Anchors: word 3 = 0x12345678, then write 1032 / read 1036.
    do_txn(0, 0, 32'd1036, 32'h12345678, 0, 0);
    wl0 = we_low_cnt;
    do_txn(0, 0, 32'd1032, 32'hDEADBEEF, 0, 0);
    check("we_low_cycles", 128'(we_low_cnt - wl0), 128'(4));
    check("write_word_addr", 128'(last_we_addr), 128'(2));
    check("mem_word2", 128'(mem[2]), 128'h0DEADBEEF);
    idle(1);
    do_txn(1, 0, 32'd1036, 32'h0, 0, 0);
    check("burst_literal", 128'(bus.readData), 128'h12345678_DEADBEEF);

    wl0 = we_low_cnt;
    do_txn(1, 1, BASE + 32'd8, 32'hAAAA5555, 0, 0);
    check("both_no_write", 128'(we_low_cnt - wl0), 128'(0));

    do_txn(0, 0, BASE + 32'd16, 32'hCAFEF00D, 0, 1);
    do_txn(1, 0, BASE + 32'd20, 32'h0, 0, 0);

    for (int n = 0; n < 60; n++) begin
      bit rd, both, drop, hold;
      logic [31:0] addr;
      rd   = ($urandom % 2) == 0;
      both = rd && (($urandom % 4) == 0);
      drop = ($urandom % 3) == 0;
      hold = ($urandom % 2) == 0;
      addr = BASE + ($urandom % 16) * 4 + ($urandom % 4);
      if (($urandom % 10) == 0) addr = $urandom;
      do_txn(rd, both, addr, $urandom, drop, hold);
      if (!hold) idle($urandom % 3);
    end

    // Reset during beat 1 of a read.
    @(posedge clk); #1;
    exp_valid = 0;
    bus.read_en = 1'b1; bus.write_en = 1'b0; bus.address = BASE + 32'd36;
    repeat (W + 3) @(posedge clk);
    #2;
    check("pre_rst_beat0", 128'(bus.readData[31:0]), 128'(model_rd(AW'(8))));
    rst = 1'b1; bus.read_en = 1'b0;
    #1;
    check("mid_rst_readData", 128'(bus.readData), 128'(0));
    check("mid_rst_we_n", 128'(we_n), 128'(1));
    check("mid_rst_sram_addr", 128'(sram_addr), 128'(0));
    check("mid_rst_dq_released", 128'(dq), 128'(dev_drive));
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    check("ready_after_mid_rst", 128'(bus.ready), 128'(1));
    exp_rdata = '0;
    idle(2);
    for (int n = 0; n < 8; n++) do_txn(($urandom % 2) == 0, 0, BASE + ($urandom % 16) * 4, $urandom, 0, 0);

    // Zero wait states, four-beat burst on the second instance.
    @(posedge clk); #1;
    bus2.read_en = 1'b1; bus2.address = BASE + 32'd20;
    done_t = -1;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      check("dut2_we_n", 128'(we_n2), 128'(1));
      if (t == 2) begin
        exp2 = 128'(model_rd(AW'(4)));
        check("dut2_partial", bus2.readData, exp2);
      end
      if (bus2.ready) begin done_t = t; break; end
    end
    bus2.read_en = 1'b0;
    check("dut2_latency", 128'(done_t), 128'(5));
    exp2 = {model_rd(AW'(7)), model_rd(AW'(6)), model_rd(AW'(5)), model_rd(AW'(4))};
    check("dut2_burst", bus2.readData, exp2);

    @(negedge clk);
    exp_valid = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
